// File: rtl/fpu_32_to_int.sv
// rtl/fpu_32_to_int.sv - FP32 to signed int32 converter, truncating toward zero
// The significand is aligned by a one-bit-per-cycle shifter behind a valid/ready handshake.
module fpu_32_to_int (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mag_q, mag_d;
   logic        left_q, left_d;
   logic        sign_q, sign_d;
   logic        special_q, special_d;
   logic [31:0] spec_res_q, spec_res_d;
   logic        spec_ovf_q, spec_ovf_d;
   logic        spec_unf_q, spec_unf_d;
   logic [31:0] result_q, result_d;
   logic        overflow_q, overflow_d;
   logic        underflow_q, underflow_d;

   logic [7:0]  exp_a;
   logic [22:0] man_a;
   logic        accept;

   logic        dec_special;
   logic [31:0] dec_res;
   logic        dec_ovf;
   logic        dec_unf;
   logic [4:0]  dec_cnt;
   logic        dec_left;
   logic [31:0] dec_mag;

   assign exp_a  = a[30:23];
   assign man_a  = a[22:0];
   assign accept = in_valid && (state_q == IDLE);

   // Classify the incoming operand; everything except 1.0 <= |a| < 2^31 resolves with cnt = 0.
   always_comb begin
      dec_special = 1'b1;
      dec_res     = 32'd0;
      dec_ovf     = 1'b0;
      dec_unf     = 1'b0;
      dec_cnt     = 5'd0;
      dec_left    = 1'b0;
      dec_mag     = 32'd0;
      if (exp_a == 8'd255) begin
         dec_ovf = 1'b1;
         dec_res = (!a[31] && (man_a == 23'd0)) ? INT_MAX : INT_MIN;
      end else if (exp_a == 8'd0) begin
         dec_unf = (man_a != 23'd0);
      end else if (exp_a < 8'd127) begin
         dec_unf = 1'b1;
      end else if (exp_a >= 8'd158) begin
         if (a == 32'hCF00_0000) begin
            dec_res = INT_MIN;
         end else begin
            dec_ovf = 1'b1;
            dec_res = a[31] ? INT_MIN : INT_MAX;
         end
      end else begin
         dec_special = 1'b0;
         dec_mag     = {8'b0, 1'b1, man_a};
         if (exp_a < 8'd150) begin
            dec_left = 1'b0;
            dec_cnt  = 5'(8'd150 - exp_a);
         end else begin
            dec_left = 1'b1;
            dec_cnt  = 5'(exp_a - 8'd150);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         mag_q       <= 32'd0;
         left_q      <= 1'b0;
         sign_q      <= 1'b0;
         special_q   <= 1'b0;
         spec_res_q  <= 32'd0;
         spec_ovf_q  <= 1'b0;
         spec_unf_q  <= 1'b0;
         result_q    <= 32'd0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mag_q       <= mag_d;
         left_q      <= left_d;
         sign_q      <= sign_d;
         special_q   <= special_d;
         spec_res_q  <= spec_res_d;
         spec_ovf_q  <= spec_ovf_d;
         spec_unf_q  <= spec_unf_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (cnt_q == 5'd0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      mag_d       = mag_q;
      left_d      = left_q;
      sign_d      = sign_q;
      special_d   = special_q;
      spec_res_d  = spec_res_q;
      spec_ovf_d  = spec_ovf_q;
      spec_unf_d  = spec_unf_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (accept) begin
         cnt_d      = dec_cnt;
         mag_d      = dec_mag;
         left_d     = dec_left;
         sign_d     = a[31];
         special_d  = dec_special;
         spec_res_d = dec_res;
         spec_ovf_d = dec_ovf;
         spec_unf_d = dec_unf;
      end else if (state_q == SHIFT) begin
         if (cnt_q != 5'd0) begin
            mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
            cnt_d = cnt_q - 5'd1;
         end else if (special_q) begin
            result_d    = spec_res_q;
            overflow_d  = spec_ovf_q;
            underflow_d = spec_unf_q;
         end else begin
            // mag never exceeds 2^31-1 here, so the negation cannot wrap.
            result_d    = sign_q ? (32'd0 - mag_q) : mag_q;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      result    = result_q;
      overflow  = overflow_q;
      underflow = underflow_q;
   end

endmodule

// File: tb/tb_fpu_32_to_int.sv
// tb/tb_fpu_32_to_int.sv - directed vector bench for fpu_32_to_int
module tb_fpu_32_to_int;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;

   int n_applied = 0;
   int n_miss    = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   fpu_32_to_int dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] av, input logic [31:0] rv,
                               input logic ov, input logic uv, input int lv);
      vec_t v;
      v.a   = av;
      v.res = rv;
      v.ovf = ov;
      v.unf = uv;
      v.lat = lv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_applied++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] op, output logic [31:0] r,
                         output logic o, output logic u, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1;
      a        = op;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = result;
      o = overflow;
      u = underflow;
   endtask

   task automatic release_out(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
      check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic        o, u;
      int          lat;
      string       nm;

      vecs.push_back(mk(32'h42F6E666, 32'h0000007B, 1'b0, 1'b0, 18));
      vecs.push_back(mk(32'hC2F60000, 32'hFFFFFF85, 1'b0, 1'b0, 18));
      vecs.push_back(mk(32'h3F800000, 32'h00000001, 1'b0, 1'b0, 24));
      vecs.push_back(mk(32'h4E800000, 32'h40000000, 1'b0, 1'b0, 8));
      vecs.push_back(mk(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 8));
      vecs.push_back(mk(32'hCEFFFFFF, 32'h80000080, 1'b0, 1'b0, 8));
      vecs.push_back(mk(32'h4B000000, 32'h00800000, 1'b0, 1'b0, 1));
      vecs.push_back(mk(32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1));
      vecs.push_back(mk(32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1));
      vecs.push_back(mk(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1));
      vecs.push_back(mk(32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1));
      vecs.push_back(mk(32'h7FC00000, 32'h80000000, 1'b1, 1'b0, 1));
      vecs.push_back(mk(32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1));
      vecs.push_back(mk(32'hBF7D70A4, 32'h00000000, 1'b0, 1'b1, 1));
      vecs.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1));
      vecs.push_back(mk(32'h80000000, 32'h00000000, 1'b0, 1'b0, 1));
      vecs.push_back(mk(32'h00000001, 32'h00000000, 1'b0, 1'b1, 1));

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", result, 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset underflow", 32'(underflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, r, o, u, lat);
         nm = $sformatf("v%0d(%h)", i, vecs[i].a);
         check({nm, " result"}, r, vecs[i].res);
         check({nm, " overflow"}, 32'(o), 32'(vecs[i].ovf));
         check({nm, " underflow"}, 32'(u), 32'(vecs[i].unf));
         check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
         release_out(nm);
      end

      // Backpressure: hold the 123.45 result while a new operand waits.
      run_op(32'h42F6E666, r, o, u, lat);
      check("bp first result", r, 32'h0000007B);
      check("bp first latency", 32'(lat), 32'd18);
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'h3F800000;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp hold%0d result", c), result, 32'h0000007B);
         check($sformatf("bp hold%0d flags", c), {30'd0, overflow, underflow}, 32'd0);
         check($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp handshake in_ready", 32'(in_ready), 32'd1);
      check("bp handshake out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp second accept", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp second latency", 32'(lat), 32'd24);
      check("bp second result", result, 32'h00000001);
      release_out("bp second");

      // Reset during the SHIFT phase of 1.0 aborts it immediately.
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'h3F800000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset in_ready", 32'(in_ready), 32'd1);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset result", result, 32'd0);
      check("midreset flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("midreset nothing emitted", 32'(out_valid), 32'd0);
      run_op(32'hC0F00000, r, o, u, lat);
      check("post reset result", r, 32'hFFFFFFF9);
      check("post reset latency", 32'(lat), 32'd22);
      check("post reset flags", {30'd0, o, u}, 32'd0);
      release_out("post reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
